// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop sync, per-key debounce FSM, level + press/release strobes.
// Optional auto-repeat of key_press while held, enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_e;

  logic          sync_q1, sync_q2, s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_d, release_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  assign s = ~sync_q2;

`ifdef KEY_AUTOREPEAT_EN
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  // Reloading to HOLD-REPEAT makes every later pulse land REPEAT cycles apart.
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);
  logic [HW-1:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYCLES[0], REPEAT_CYCLES[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    hold_d    = '0;
`endif
    case (state_q)
      RELEASED: if (s) begin
        state_d = PRESS_CHK;
        cnt_d   = CW'(1);
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_CHK;
          cnt_d   = CW'(1);
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (hold_q == HOLD_LAST) begin
          press_d = 1'b1;
          hold_d  = HOLD_RELOAD;
        end else begin
          hold_d = hold_q + HW'(1);
        end
`endif
      end
      RELEASE_CHK: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_level = (state_q == PRESSED) || (state_q == RELEASE_CHK);

endmodule

module key_debounce #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);
  key_debounce_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_lane [NUM_KEYS-1:0] (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE=4, HOLD=10, REPEAT=3.
module tb_key_debounce;
  logic       clk;
  logic       rst_n;
  logic [2:0] key_n;
  logic [2:0] key_level, key_press, key_release;
  int checks = 0;
  int errors = 0;

  key_debounce #(
    .NUM_KEYS       (3),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, leaving time 1 unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    key_n = 3'b111;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    logic [2:0] ep, el;
    key_n = 3'b000;
    rst_n = 1'b0;
    step(3);
    checks++;
    if ({key_level, key_press, key_release} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b expected all 0", key_level, key_press, key_release);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      ep = (k == 6) ? 3'b111 : 3'b000;
      el = (k >= 6) ? 3'b111 : 3'b000;
      checks++;
      if (key_press !== ep || key_level !== el) begin
        errors++;
        $display("FAIL reset_held_press k=%0d: got prs=%b lvl=%b expected prs=%b lvl=%b", k, key_press, key_level, ep, el);
      end
    end
    key_n = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      ep = (k == 6) ? 3'b111 : 3'b000;
      checks++;
      if (key_release !== ep || key_press !== 3'b000) begin
        errors++;
        $display("FAIL reset_held_release k=%0d: got rel=%b prs=%b expected rel=%b prs=000", k, key_release, key_press, ep);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] ep, er, el;
    do_reset();
    key_n[1] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      ep = (k == 6) ? 3'b010 : 3'b000;
      er = (k == 26) ? 3'b010 : 3'b000;
      el = (k >= 6 && k < 26) ? 3'b010 : 3'b000;
      checks++;
      if (key_press !== ep || key_release !== er || key_level !== el) begin
        errors++;
        $display("FAIL clean k=%0d: got prs=%b rel=%b lvl=%b expected prs=%b rel=%b lvl=%b",
                 k, key_press, key_release, key_level, ep, er, el);
      end
      if (k == 20) key_n[1] = 1'b1;
    end
  endtask

  task automatic test_bounce();
    int pulses;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < 4; c++) begin
        key_n[0] = (c == 3);
        step(1);
        checks++;
        if (key_press !== 3'b000 || key_release !== 3'b000 || key_level !== 3'b000) begin
          errors++;
          $display("FAIL bounce b=%0d c=%0d: got prs=%b rel=%b lvl=%b expected all 000", b, c, key_press, key_release, key_level);
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      step(1);
      checks++;
      if (key_press !== 3'b000 || key_level !== 3'b000) begin
        errors++;
        $display("FAIL bounce_tail k=%0d: got prs=%b lvl=%b expected 000", k, key_press, key_level);
      end
    end
    key_n[0] = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (key_press[0]) pulses++;
    end
    checks++;
    if (pulses != 1 || key_level !== 3'b001) begin
      errors++;
      $display("FAIL bounce_accept: got pulses=%0d lvl=%b expected pulses=1 lvl=001", pulses, key_level);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] ep;
    do_reset();
    key_n = 3'b010;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      ep = (k == 6) ? 3'b101 : 3'b000;
      checks++;
      if (key_press !== ep) begin
        errors++;
        $display("FAIL simul_press k=%0d: got prs=%b expected %b", k, key_press, ep);
      end
    end
    checks++;
    if (key_level !== 3'b101) begin
      errors++;
      $display("FAIL simul_level: got %b expected 101", key_level);
    end
    key_n = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      ep = (k == 6) ? 3'b101 : 3'b000;
      checks++;
      if (key_release !== ep || key_press !== 3'b000) begin
        errors++;
        $display("FAIL simul_release k=%0d: got rel=%b prs=%b expected rel=%b prs=000", k, key_release, key_press, ep);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ep;
    do_reset();
    key_n[2] = 1'b0;
    step(3);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++;
      if ({key_level, key_press, key_release} !== 9'b0) begin
        errors++;
        $display("FAIL midreset_hold k=%0d: got lvl=%b prs=%b rel=%b expected all 0", k, key_level, key_press, key_release);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      ep = (k == 6) ? 3'b100 : 3'b000;
      checks++;
      if (key_press !== ep) begin
        errors++;
        $display("FAIL midreset_redetect k=%0d: got prs=%b expected %b", k, key_press, ep);
      end
    end
    // Asynchronous clear while the key is accepted and held.
    rst_n = 1'b0;
    #2;
    checks++;
    if (key_level !== 3'b000 || key_press !== 3'b000) begin
      errors++;
      $display("FAIL async_clear: got lvl=%b prs=%b expected 000", key_level, key_press);
    end
    step(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      ep = (k == 6) ? 3'b100 : 3'b000;
      checks++;
      if (key_press !== ep) begin
        errors++;
        $display("FAIL holdreset_redetect k=%0d: got prs=%b expected %b", k, key_press, ep);
      end
    end
    key_n = 3'b111;
    step(8);
  endtask

  task automatic test_autorepeat();
    logic [2:0] ep;
    logic       rep;
    do_reset();
    key_n[1] = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      step(1);
`ifdef KEY_AUTOREPEAT_EN
      rep = (k >= 16) && ((k - 16) % 3 == 0);
`else
      rep = 1'b0;
`endif
      ep = ((k == 6) || rep) ? 3'b010 : 3'b000;
      checks++;
      if (key_press !== ep || key_release !== 3'b000) begin
        errors++;
        $display("FAIL autorepeat k=%0d: got prs=%b rel=%b expected prs=%b rel=000", k, key_press, key_release, ep);
      end
    end
    key_n = 3'b111;
    step(8);
    checks++;
    if (key_level !== 3'b000) begin
      errors++;
      $display("FAIL autorepeat_release: got lvl=%b expected 000", key_level);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 3'b000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_autorepeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream conditioning stage for the board push-buttons (active-low KEYx pins).
- Per key: synchronises the raw input, rejects contact bounce with a per-key stability counter, and produces a clean level plus single-cycle press/release strobes.
- The strobes drive the LED counter's reset/inc/dec inputs directly, with no further edge detection downstream.

Parameters:
- NUM_KEYS, 3, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before accepting a change (10 ms at 50 MHz); legal range >= 2.
- HOLD_CYCLES, 25000000, auto-repeat initial hold delay in cycles (used only with KEY_AUTOREPEAT_EN).
- REPEAT_CYCLES, 5000000, auto-repeat period in cycles (used only with KEY_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- key_n  input  NUM_KEYS  raw asynchronous button pins, 0 = pressed.
- key_level  output  NUM_KEYS  debounced state, 1 = pressed.
- key_press  output  NUM_KEYS  one-cycle strobe on accepted press (and on repeats, if enabled).
- key_release  output  NUM_KEYS  one-cycle strobe on accepted release.

Behaviour:
- One clock; reset is asynchronous and active-low; ports named clk and rst_n.
- Reset: sync flops = 1 (released); key_level = 0; key_press = 0; key_release = 0; all counters = 0; all FSMs in RELEASED.
- Synchroniser: 2-flop chain per key. The sync output is s = ~sync_q2 (1 = pressed).
- Per-key FSM with four states:
  - RELEASED: if s = 1, go to PRESS_CHK with cnt = 1.
  - PRESS_CHK: if s = 0, return to RELEASED with cnt = 0. Else, if cnt = DEBOUNCE_CYCLES-1, go to PRESSED; else cnt++.
  - PRESSED: if s = 0, go to RELEASE_CHK with cnt = 1.
  - RELEASE_CHK: if s = 1, return to PRESSED with cnt = 0. Else, if cnt = DEBOUNCE_CYCLES-1, go to RELEASED; else cnt++.
- Outputs:
  - key_level = 1 in PRESSED and RELEASE_CHK.
  - key_press is a registered 1-cycle pulse on the PRESS_CHK -> PRESSED transition.
  - key_release is a registered 1-cycle pulse on the RELEASE_CHK -> RELEASED transition.
  - key_press and key_release assert in the same cycle that key_level changes.
- Latency:
  - key_n held low from before edge E0: key_press and key_level = 1 visible after edge E0 + 2 + DEBOUNCE_CYCLES.
  - Release has the same latency.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES produces no strobe and no level change. The counter restarts from the first stable cycle after the glitch.
- Counter width: clog2(DEBOUNCE_CYCLES) + 1 bits. The counter never wraps, because it saturates at the transition.
- Channels are fully independent. Simultaneous accepted events on several keys produce strobes in the same cycle.
- key_press and key_release are never both high on the same key.
- rst_n asserted mid-debounce or mid-hold: immediate return to the reset state, with no strobe emitted. After rst_n deasserts with the key still held, a fresh full press is detected after the normal latency.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Per key, a hold counter runs while in PRESSED.
  - After HOLD_CYCLES in PRESSED, key_press pulses once, then again every REPEAT_CYCLES, while the FSM stays in PRESSED.
  - The hold counter clears on entry to RELEASE_CHK; a bounce back to PRESSED restarts the hold delay.
- Undefined: hold logic is absent; exactly one key_press per accepted press.

Test Plan (bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3):
- Reset: rst_n = 0 with key_n = 3'b000 -> all outputs 0. After release of rst_n with key_n held = 000, key_press = 3'b111 for exactly 1 cycle at edge 6 after deassert; key_level = 111 thereafter.
- Clean press/release: key_n[1] falls at E0 -> key_press[1] high only in the cycle after E6. key_n[1] rises at E20 -> key_release[1] high only in the cycle after E26. key_level[1] = 1 from E6 to E26.
- Bounce: key_n[0] toggles low 3 cycles / high 1 cycle, five times, then stays high -> no strobes, key_level[0] stays 0. Then held low for 4+ cycles -> exactly one press strobe.
- Simultaneous: key_n[2] and key_n[0] fall on the same edge -> key_press = 3'b101 in a single cycle; key_press[1] stays 0.
- Reset mid-debounce: key_n[2] low for 3 cycles, then rst_n pulse -> no strobe; outputs 0 during reset; full detection restarts after deassert.
- Auto-repeat (KEY_AUTOREPEAT_EN): hold key_n[1] low for 30 cycles past acceptance -> key_press[1] pulses at acceptance, +10, +13, +16, ... Undefined: a single pulse only.
